// File: rtl/sc_outcapture_pkg.sv
// Shared types and defaults for the output-capture stage.
// Imported by the capture top and its FIFO.
package sc_outcapture_pkg;
  localparam int DATAWIDTH_BUS_DEF = 32;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int DATAWIDTH_FIFO_PTR_DEF = 2;
  localparam int DATAWIDTH_DROPCOUNT_DEF = 8;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    PRIME    = 2'd1,
    TRACK    = 2'd2
  } cap_state_e;
endpackage

// File: rtl/sc_outcapture_fifo.sv
// Show-ahead circular buffer with push/pop/clear and occupancy.
// Head data reads as zero while empty.
module sc_outcapture_fifo
  import sc_outcapture_pkg::*;
#(
  parameter int W = DATAWIDTH_BUS_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int PW = DATAWIDTH_FIFO_PTR_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [PW:0]   level_o
);
  localparam logic [PW:0] FULL_LVL = DEPTH[PW:0];

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   level_q, level_d;
  logic          push_ok, pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == FULL_LVL);
  assign level_o = level_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  assign pop_ok  = pop_i & ~empty_o & ~clear_i;
  assign push_ok = push_i & (~full_o | pop_ok) & ~clear_i;

  always_comb begin
    level_d = level_q;
    unique case (1'b1)
      push_ok & ~pop_ok: level_d = level_q + 1'b1;
      pop_ok & ~push_ok: level_d = level_q - 1'b1;
      default:           level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else if (clear_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: contents are masked by level.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/sc_outcapture.sv
// Captures every change of the datapath result bus into a FIFO,
// with sticky overflow and a saturating drop counter.
module sc_outcapture
  import sc_outcapture_pkg::*;
#(
  parameter int DATAWIDTH_BUS = DATAWIDTH_BUS_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int DATAWIDTH_FIFO_PTR = DATAWIDTH_FIFO_PTR_DEF,
  parameter int DATAWIDTH_DROPCOUNT = DATAWIDTH_DROPCOUNT_DEF
) (
  input  logic                           SC_OUTCAPTURE_CLOCK_50,
  input  logic                           SC_OUTCAPTURE_RESET_InLow,
  input  logic [DATAWIDTH_BUS-1:0]       SC_OUTCAPTURE_data_InBUS,
  input  logic                           SC_OUTCAPTURE_enable_InHigh,
  input  logic                           SC_OUTCAPTURE_clear_InHigh,
  input  logic                           SC_OUTCAPTURE_ready_InHigh,
  output logic [DATAWIDTH_BUS-1:0]       SC_OUTCAPTURE_data_OutBUS,
  output logic                           SC_OUTCAPTURE_valid_OutHigh,
  output logic                           SC_OUTCAPTURE_empty_OutHigh,
  output logic                           SC_OUTCAPTURE_full_OutHigh,
  output logic [DATAWIDTH_FIFO_PTR:0]    SC_OUTCAPTURE_level_OutBUS,
  output logic                           SC_OUTCAPTURE_overflow_OutHigh,
  output logic [DATAWIDTH_DROPCOUNT-1:0] SC_OUTCAPTURE_dropcount_OutBUS
);
  cap_state_e state_q, state_d;
  logic [DATAWIDTH_BUS-1:0] last_q, last_d;
  logic [DATAWIDTH_DROPCOUNT-1:0] drop_q;
  logic ovf_q;
  logic push_req, push, pop, drop;
  logic en, clr, empty, full;

  assign en  = SC_OUTCAPTURE_enable_InHigh;
  assign clr = SC_OUTCAPTURE_clear_InHigh;

  always_comb begin
    state_d  = state_q;
    push_req = 1'b0;
    if (!en) begin
      state_d = DISABLED;
    end else begin
      unique case (state_q)
        DISABLED: state_d = PRIME;
        PRIME: begin
          push_req = 1'b1;
          state_d  = TRACK;
        end
        TRACK: push_req = (SC_OUTCAPTURE_data_InBUS != last_q);
        default: state_d = DISABLED;
      endcase
    end
    if (clr) state_d = en ? PRIME : DISABLED;
  end

  always_comb begin
    last_d = last_q;
    if (state_q == PRIME || state_q == TRACK)
      last_d = SC_OUTCAPTURE_data_InBUS;
  end

  assign pop  = ~empty & SC_OUTCAPTURE_ready_InHigh & ~clr;
  assign push = push_req & ~clr;
  assign drop = push & full & ~pop;

  always_ff @(posedge SC_OUTCAPTURE_CLOCK_50 or negedge SC_OUTCAPTURE_RESET_InLow) begin
    if (!SC_OUTCAPTURE_RESET_InLow) begin
      state_q <= DISABLED;
      last_q  <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      if (clr) begin
        ovf_q  <= 1'b0;
        drop_q <= '0;
      end else if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != '1) drop_q <= drop_q + 1'b1;
      end
    end
  end

  sc_outcapture_fifo #(
    .W     (DATAWIDTH_BUS),
    .DEPTH (FIFO_DEPTH),
    .PW    (DATAWIDTH_FIFO_PTR)
  ) u_fifo (
    .clk_i   (SC_OUTCAPTURE_CLOCK_50),
    .rst_ni  (SC_OUTCAPTURE_RESET_InLow),
    .clear_i (clr),
    .push_i  (push),
    .data_i  (SC_OUTCAPTURE_data_InBUS),
    .pop_i   (pop),
    .data_o  (SC_OUTCAPTURE_data_OutBUS),
    .empty_o (empty),
    .full_o  (full),
    .level_o (SC_OUTCAPTURE_level_OutBUS)
  );

  assign SC_OUTCAPTURE_valid_OutHigh    = ~empty;
  assign SC_OUTCAPTURE_empty_OutHigh    = empty;
  assign SC_OUTCAPTURE_full_OutHigh     = full;
  assign SC_OUTCAPTURE_overflow_OutHigh = ovf_q;
  assign SC_OUTCAPTURE_dropcount_OutBUS = drop_q;
endmodule

// File: tb/tb_sc_outcapture.sv
// Scoreboard bench for sc_outcapture: directed vectors queue
// expected pops; a negedge monitor compares accepted heads.
module tb_sc_outcapture;
  import sc_outcapture_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] din;
  logic        en, clr, rdy;
  logic [31:0] dout;
  logic        valid, empty, full, ovf;
  logic [2:0]  level;
  logic [7:0]  dcnt;

  int total = 0;
  int bad = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  sc_outcapture dut (
    .SC_OUTCAPTURE_CLOCK_50         (clk),
    .SC_OUTCAPTURE_RESET_InLow      (rst_n),
    .SC_OUTCAPTURE_data_InBUS       (din),
    .SC_OUTCAPTURE_enable_InHigh    (en),
    .SC_OUTCAPTURE_clear_InHigh     (clr),
    .SC_OUTCAPTURE_ready_InHigh     (rdy),
    .SC_OUTCAPTURE_data_OutBUS      (dout),
    .SC_OUTCAPTURE_valid_OutHigh    (valid),
    .SC_OUTCAPTURE_empty_OutHigh    (empty),
    .SC_OUTCAPTURE_full_OutHigh     (full),
    .SC_OUTCAPTURE_level_OutBUS     (level),
    .SC_OUTCAPTURE_overflow_OutHigh (ovf),
    .SC_OUTCAPTURE_dropcount_OutBUS (dcnt)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted head must match the queued expectation.
  always @(negedge clk) begin
    if (rst_n && valid && rdy && !clr) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got %0h want none", dout);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        if (dout !== e) begin
          bad++;
          $display("FAIL pop_data: got %0h want %0h", dout, e);
        end
      end
    end
  end

  logic [31:0] seq2 [5] = '{32'h9, 32'h9, 32'hF, 32'hF, 32'h18};
  logic [31:0] seq3 [6] = '{32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6};

  initial begin
    rst_n = 1'b0; din = '0; en = 1'b0; clr = 1'b0; rdy = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_data", dout, 32'd0);
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_dcnt", {24'd0, dcnt}, 32'd0);

    // single held value -> exactly one entry
    en = 1'b1; din = 32'h9;
    step(); step();
    chk("t1_level", {29'd0, level}, 32'd1);
    chk("t1_head", dout, 32'h9);
    chk("t1_valid", {31'd0, valid}, 32'd1);
    step(); step();
    chk("t1_level_hold", {29'd0, level}, 32'd1);
    sb.push_back(32'h9);
    rdy = 1'b1; step(); rdy = 1'b0;
    chk("t1_drained", {29'd0, level}, 32'd0);

    // change detection
    en = 1'b0; step();
    en = 1'b1; din = 32'h9; step();
    foreach (seq2[i]) begin
      din = seq2[i]; step();
    end
    chk("t2_level", {29'd0, level}, 32'd3);
    sb.push_back(32'h9); sb.push_back(32'hF); sb.push_back(32'h18);
    rdy = 1'b1; step(); step(); step(); rdy = 1'b0;
    chk("t2_drained", {29'd0, level}, 32'd0);

    // overflow: 6 distinct values into 4 slots
    foreach (seq3[i]) begin
      din = seq3[i]; step();
    end
    chk("t3_level", {29'd0, level}, 32'd4);
    chk("t3_full", {31'd0, full}, 32'd1);
    chk("t3_ovf", {31'd0, ovf}, 32'd1);
    chk("t3_dcnt", {24'd0, dcnt}, 32'd2);
    for (int i = 0; i < 4; i++) sb.push_back(seq3[i]);

    // push and pop together while full
    rdy = 1'b1; din = 32'hB7; step();
    sb.push_back(32'hB7);
    chk("t4_level", {29'd0, level}, 32'd4);
    chk("t4_head", dout, 32'hA2);
    chk("t4_dcnt", {24'd0, dcnt}, 32'd2);
    step(); step(); step(); step();
    rdy = 1'b0;
    chk("t4_drained", {29'd0, level}, 32'd0);
    chk("t4_empty", {31'd0, empty}, 32'd1);

    // saturation then clear
    for (int i = 0; i < 304; i++) begin
      din = i[0] ? 32'hC1 : 32'hC0; step();
    end
    chk("t5_dcnt_sat", {24'd0, dcnt}, 32'd255);
    chk("t5_ovf", {31'd0, ovf}, 32'd1);
    chk("t5_level", {29'd0, level}, 32'd4);
    clr = 1'b1; din = 32'hD5; step(); clr = 1'b0;
    chk("t5_clr_level", {29'd0, level}, 32'd0);
    chk("t5_clr_ovf", {31'd0, ovf}, 32'd0);
    chk("t5_clr_dcnt", {24'd0, dcnt}, 32'd0);
    chk("t5_clr_state", {30'd0, dut.state_q}, {30'd0, PRIME});
    step();
    chk("t5_prime_push", dout, 32'hD5);
    chk("t5_prime_level", {29'd0, level}, 32'd1);

    // asynchronous reset mid-stream
    din = 32'hE1; step();
    din = 32'hE2; step();
    chk("t6_level", {29'd0, level}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", {31'd0, valid}, 32'd0);
    chk("t6_empty", {31'd0, empty}, 32'd1);
    chk("t6_data", dout, 32'd0);
    chk("t6_level0", {29'd0, level}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    chk("sb_left", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
